// File: rtl/jpeg_rle_encoder.sv
// Zigzag coefficient stream -> JPEG DC/AC/ZRL/EOB symbols with amplitude bits; symbol registered one edge after acceptance.
// Backpressure: holds out_* while out_ready_i is low; stalls input during ZRL emission and while the output slot is full.
module jpeg_rle_encoder #(
   parameter int COEF_W = 12
) (
   input  logic                     clk_i,
   input  logic                     rst_i,
   input  logic                     clear_dc_i,
   input  logic                     in_valid_i,
   output logic                     in_ready_o,
   input  logic signed [COEF_W-1:0] in_coef_i,
   output logic                     out_valid_o,
   input  logic                     out_ready_i,
   output logic                     out_dc_o,
   output logic [7:0]               out_sym_o,
   output logic [11:0]              out_amp_o,
   output logic [3:0]               out_amp_size_o,
   output logic                     block_done_o
);

   typedef enum logic [1:0] {ST_ACCEPT, ST_ZRL, ST_SYM} state_t;

   typedef struct packed {
      logic        dc;
      logic [7:0]  sym;
      logic [11:0] amp;
      logic [3:0]  size;
      logic        last;
   } sym_t;

   state_t                    state, state_nxt;
   logic [5:0]                idx, idx_nxt;
   logic [5:0]                run, run_nxt;
   logic signed [12:0]        pred, pred_nxt;
   logic signed [COEF_W-1:0]  hold, hold_nxt;
   sym_t                      out_q, out_nxt;
   logic                      out_vld, vld_nxt;

   logic                      slot_free;
   logic                      accept;
   logic signed [12:0]        coef_x;
   logic signed [12:0]        hold_x;
   logic signed [12:0]        diff;
   logic signed [12:0]        enc_v;
   logic [3:0]                enc_cat;
   logic [11:0]               enc_amp;

   function automatic logic [3:0] cat_of(input logic signed [12:0] v);
      logic [12:0] mag;
      cat_of = 4'd0;
      mag    = v[12] ? 13'(-v) : 13'(v);
      for (int i = 0; i < 13; i++) begin
         if (mag[i]) cat_of = 4'(i + 1);
      end
   endfunction

   // Negative values carry the one's complement, truncated to the category width.
   function automatic logic [11:0] amp_of(input logic signed [12:0] v, input logic [3:0] c);
      logic [11:0] t;
      logic [11:0] mask;
      t      = v[12] ? 12'(v - 13'sd1) : v[11:0];
      mask   = 12'((13'd1 << c) - 13'd1);
      amp_of = t & mask;
   endfunction

   assign coef_x = {{(13-COEF_W){in_coef_i[COEF_W-1]}}, in_coef_i};
   assign hold_x = {{(13-COEF_W){hold[COEF_W-1]}}, hold};
   assign diff   = coef_x - pred;
   assign enc_v  = (state == ST_SYM) ? hold_x : ((idx == 6'd0) ? diff : coef_x);
   assign enc_cat = cat_of(enc_v);
   assign enc_amp = amp_of(enc_v, enc_cat);

   assign slot_free  = !out_vld || out_ready_i;
   assign in_ready_o = (state == ST_ACCEPT) && slot_free && !clear_dc_i && !rst_i;
   assign accept     = in_valid_i && in_ready_o;

   always_comb begin
      state_nxt = state;
      idx_nxt   = idx;
      run_nxt   = run;
      pred_nxt  = pred;
      hold_nxt  = hold;
      out_nxt   = out_q;
      vld_nxt   = out_vld;
      if (slot_free) vld_nxt = 1'b0;

      case (state)
         ST_ACCEPT: begin
            if (accept) begin
               idx_nxt = idx + 6'd1;
               if (idx == 6'd0) begin
                  pred_nxt = coef_x;
                  vld_nxt  = 1'b1;
                  out_nxt  = '{1'b1, {4'h0, enc_cat}, enc_amp, enc_cat, 1'b0};
               end else if (coef_x == 13'sd0) begin
                  if (idx == 6'd63) begin
                     // EOB discards any zeros still counted in run.
                     vld_nxt = 1'b1;
                     out_nxt = '{1'b0, 8'h00, 12'h000, 4'h0, 1'b1};
                     run_nxt = 6'd0;
                  end else begin
                     run_nxt = run + 6'd1;
                  end
               end else if (run >= 6'd16) begin
                  hold_nxt  = in_coef_i;
                  state_nxt = ST_ZRL;
               end else begin
                  vld_nxt = 1'b1;
                  out_nxt = '{1'b0, {run[3:0], enc_cat}, enc_amp, enc_cat, idx == 6'd63};
                  run_nxt = 6'd0;
               end
            end
         end
         ST_ZRL: begin
            if (slot_free) begin
               vld_nxt = 1'b1;
               out_nxt = '{1'b0, 8'hF0, 12'h000, 4'h0, 1'b0};
               run_nxt = run - 6'd16;
               if (run < 6'd32) state_nxt = ST_SYM;
            end
         end
         ST_SYM: begin
            if (slot_free) begin
               // idx has already wrapped to 0 when the parked coefficient was position 63.
               vld_nxt   = 1'b1;
               out_nxt   = '{1'b0, {run[3:0], enc_cat}, enc_amp, enc_cat, idx == 6'd0};
               run_nxt   = 6'd0;
               state_nxt = ST_ACCEPT;
            end
         end
         default: state_nxt = ST_ACCEPT;
      endcase

      if (clear_dc_i) begin
         state_nxt = ST_ACCEPT;
         idx_nxt   = 6'd0;
         run_nxt   = 6'd0;
         pred_nxt  = 13'sd0;
         vld_nxt   = 1'b0;
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state   <= ST_ACCEPT;
         idx     <= 6'd0;
         run     <= 6'd0;
         pred    <= 13'sd0;
         hold    <= '0;
         out_q   <= '0;
         out_vld <= 1'b0;
      end else begin
         state   <= state_nxt;
         idx     <= idx_nxt;
         run     <= run_nxt;
         pred    <= pred_nxt;
         hold    <= hold_nxt;
         out_q   <= out_nxt;
         out_vld <= vld_nxt;
      end
   end

   assign out_valid_o    = out_vld;
   assign out_dc_o       = out_q.dc;
   assign out_sym_o      = out_q.sym;
   assign out_amp_o      = out_q.amp;
   assign out_amp_size_o = out_q.size;
   assign block_done_o   = out_vld && out_ready_i && out_q.last;

endmodule
